write_back_stage: RTL

//  Registered, parametrised successor of the combinational write-back mux: the final DLX pipeline stage.
//  - Selects ALU or load data.
//  - Extracts and sign/zero-extends byte/halfword loads.
//  - Waits for variable-latency memory data, with a timeout.
//  - Drives the register-file write port and the forwarding path.

---
 rtl/write_back_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/write_back_stage.sv
// DLX write-back stage: selects ALU or extended load data, waits for slow memory with
// a timeout, and drives the register-file write port and forwarding path.
module write_back_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OFF_WIDTH      = 2,
    parameter bit R0_HARDWIRED   = 1'b1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic                      stall_in,
    input  logic                      flush_in,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic                      mem_data_valid_in,
    input  logic [DATA_WIDTH-1:0]     alu_data_in,
    input  logic                      write_back_mux_sel,
    input  logic [1:0]                load_size_in,
    input  logic                      load_unsigned_in,
    input  logic [OFF_WIDTH-1:0]      byte_offset_in,
    input  logic                      reg_wr_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
    output logic                      reg_wr_en_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
    output logic [DATA_WIDTH-1:0]     reg_wr_data_out,
    output logic                      wb_busy_out,
    output logic                      wb_timeout_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [REG_ADDR_WIDTH-1:0] cap_addr;
    logic [1:0]                cap_size;
    logic                      cap_unsigned;
    logic [OFF_WIDTH-1:0]      cap_offset;
    logic                      cap_we;
    logic                      accept;

    // Big-endian lane select: lane 0 is the most significant byte of the bus.
    function automatic logic [DATA_WIDTH-1:0] extract(
        input logic [DATA_WIDTH-1:0] data,
        input logic [1:0]            size,
        input logic                  uns,
        input logic [OFF_WIDTH-1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        int          lane;
        int          half;
        lane = int'(off);
        half = int'(off >> 1);
        b = data[DATA_WIDTH-1-8*lane -: 8];
        h = data[DATA_WIDTH-1-16*half -: 16];
        case (size)
            2'b00:   extract = {{(DATA_WIDTH-8){~uns & b[7]}}, b};
            2'b01:   extract = {{(DATA_WIDTH-16){~uns & h[15]}}, h};
            default: extract = data;
        endcase
    endfunction

    function automatic logic write_allowed(input logic we, input logic [REG_ADDR_WIDTH-1:0] addr);
        write_allowed = we & ~(R0_HARDWIRED & (addr == '0));
    endfunction

    assign accept      = valid_in & ~stall_in & ~flush_in & (state == IDLE);
    assign wb_busy_out = (state == WAIT_MEM);

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            cap_addr        <= '0;
            cap_size        <= '0;
            cap_unsigned    <= 1'b0;
            cap_offset      <= '0;
            cap_we          <= 1'b0;
            reg_wr_en_out   <= 1'b0;
            reg_wr_addr_out <= '0;
            reg_wr_data_out <= '0;
            wb_timeout_out  <= 1'b0;
        end else begin
            reg_wr_en_out  <= 1'b0;
            wb_timeout_out <= 1'b0;
            if (flush_in) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (!write_back_mux_sel || mem_data_valid_in) begin
                                // Address/data only move on a real write so the forwarding path holds.
                                if (write_allowed(reg_wr_en_in, reg_wr_addr_in)) begin
                                    reg_wr_en_out   <= 1'b1;
                                    reg_wr_addr_out <= reg_wr_addr_in;
                                    reg_wr_data_out <= write_back_mux_sel
                                        ? extract(mem_data_in, load_size_in, load_unsigned_in, byte_offset_in)
                                        : alu_data_in;
                                end
                            end else begin
                                state        <= WAIT_MEM;
                                cnt          <= '0;
                                cap_addr     <= reg_wr_addr_in;
                                cap_size     <= load_size_in;
                                cap_unsigned <= load_unsigned_in;
                                cap_offset   <= byte_offset_in;
                                cap_we       <= reg_wr_en_in;
                            end
                        end
                    end
                    WAIT_MEM: begin
                        if (mem_data_valid_in) begin
                            state <= IDLE;
                            cnt   <= '0;
                            if (write_allowed(cap_we, cap_addr)) begin
                                reg_wr_en_out   <= 1'b1;
                                reg_wr_addr_out <= cap_addr;
                                reg_wr_data_out <= extract(mem_data_in, cap_size, cap_unsigned, cap_offset);
                            end
                        end else if (cnt == CNT_LAST) begin
                            state          <= IDLE;
                            cnt            <= '0;
                            wb_timeout_out <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
